// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit pair per clock, LSB first.
// Result, borrow and zero flag are published together with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_diff,
    output logic             out_borrow,
    output logic             out_zero
);

    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [WIDTH-1:0] r_diff;
    logic             r_out_borrow;
    logic             r_out_zero;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_diff_bit;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_accept;
    logic             w_last;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign w_a_bit       = r_a[0];
    assign w_b_bit       = r_b[0];
    assign w_diff_bit    = w_a_bit ^ w_b_bit ^ r_borrow;
    assign w_borrow_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
    assign w_res_next    = {w_diff_bit, r_res[WIDTH-1:1]};

    assign w_accept = (r_state == IDLE) && in_start;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_start) w_next_state = SHIFT;
            SHIFT:   if (w_last)   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        // NOTE: the operand/result shift registers are plain flops, so they take the async clear too.
        if (!in_rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_a      <= in_a;
            r_b      <= in_b;
            r_res    <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_cnt    <= r_cnt + CNT_ONE;
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_res    <= w_res_next;
            r_borrow <= w_borrow_next;
        end
    end

    // Published results change only on the final shift, i.e. on entry to DONE.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_diff       <= '0;
            r_out_borrow <= 1'b0;
            r_out_zero   <= 1'b0;
        end else if (w_last) begin
            r_diff       <= w_res_next;
            r_out_borrow <= w_borrow_next;
            r_out_zero   <= (w_res_next == '0);
        end
    end

    assign out_busy   = (r_state == SHIFT);
    assign out_done   = (r_state == DONE);
    assign out_diff   = r_diff;
    assign out_borrow = r_out_borrow;
    assign out_zero   = r_out_zero;

    a_busy_done_exclusive : assert property (
        @(posedge in_clk) disable iff (!in_rst_n) !(out_busy && out_done)
    );

endmodule
